// File: rtl/peridot_pfc_sequencer.sv
// peridot_pfc_sequencer: shares the pin function controller between requesters and programs it over Avalon-MM.
// Define PERIDOT_PFC_SEQ_TIMEOUT_EN to abandon writes stalled for 255 cycles and raise a sticky err.
module peridot_pfc_sequencer #(
    parameter int          NUM_REQ          = 4,
    parameter logic [31:0] DEFAULT_PINREGS  = 32'h0000_0000,
    parameter logic [31:0] DEFAULT_FUNCREGS = 32'h0000_0000
) (
    input  logic                   clock_sig,
    input  logic                   reset_sig,
    output logic [1:0]             avm_address,
    output logic                   avm_write,
    output logic [31:0]            avm_writedata,
    input  logic                   avm_waitrequest,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_pinmask,
    input  logic [32*NUM_REQ-1:0]  req_pinsel,
    input  logic [8*NUM_REQ-1:0]   req_funcmask,
    input  logic [32*NUM_REQ-1:0]  req_funcsel,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [7:0]             owned_pins,
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
    output logic                   err,
`endif
    output logic                   busy
);
    typedef enum logic [2:0] {INIT_PIN, INIT_FUNC, IDLE, WR_PIN, WR_FUNC} state_t;
    state_t state, state_n;
    logic [1:0] cur, cur_n, rr_ptr, rr_ptr_n, addr_n;
    logic acq, acq_n, wr_n, done;
    logic [NUM_REQ-1:0] gnt_n;
    logic [7:0] owned_pins_n, owned_funcs, owned_funcs_n;
    logic [31:0] pin_sh, pin_sh_n, func_sh, func_sh_n, data_n;
    logic [8*NUM_REQ-1:0] lat_pin, lat_pin_n, lat_func, lat_func_n;
    int rel, sel, k;
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic [31:0] pin_save, func_save;
    logic abort;
`endif

    function automatic logic [31:0] nib(input logic [7:0] m);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = {4{m[i]}};
        return r;
    endfunction

    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cur_n = cur;
        acq_n = acq;
        rr_ptr_n = rr_ptr;
        gnt_n = gnt;
        owned_pins_n = owned_pins;
        owned_funcs_n = owned_funcs;
        pin_sh_n = pin_sh;
        func_sh_n = func_sh;
        lat_pin_n = lat_pin;
        lat_func_n = lat_func;
        wr_n = avm_write;
        addr_n = avm_address;
        data_n = avm_writedata;
        done = avm_write && !avm_waitrequest;
        rel = -1;
        sel = -1;
        k = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (gnt[i] && !req[i]) rel = i;
        // round-robin search for a non-conflicting claimant, starting at rr_ptr
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (sel < 0 && req[k] && !gnt[k] && !(|(req_pinmask[8*k +: 8] & owned_pins))
                && !(|(req_funcmask[8*k +: 8] & owned_funcs))) sel = k;
        end
        case (state)
            INIT_PIN: begin
                if (!avm_write) begin
                    wr_n = 1'b1;
                    addr_n = 2'd2;
                    data_n = DEFAULT_PINREGS;
                end else if (done) begin
                    state_n = INIT_FUNC;
                    addr_n = 2'd3;
                    data_n = DEFAULT_FUNCREGS;
                end
            end
            INIT_FUNC: if (done) begin
                state_n = IDLE;
                wr_n = 1'b0;
            end
            IDLE: begin
                if (rel >= 0) begin
                    gnt_n[rel] = 1'b0;
                    owned_pins_n = owned_pins & ~lat_pin[8*rel +: 8];
                    owned_funcs_n = owned_funcs & ~lat_func[8*rel +: 8];
                    pin_sh_n = (pin_sh & ~nib(lat_pin[8*rel +: 8])) | (DEFAULT_PINREGS & nib(lat_pin[8*rel +: 8]));
                    func_sh_n = (func_sh & ~nib(lat_func[8*rel +: 8])) | (DEFAULT_FUNCREGS & nib(lat_func[8*rel +: 8]));
                    acq_n = 1'b0;
                end else if (sel >= 0) begin
                    lat_pin_n[8*sel +: 8] = req_pinmask[8*sel +: 8];
                    lat_func_n[8*sel +: 8] = req_funcmask[8*sel +: 8];
                    owned_pins_n = owned_pins | req_pinmask[8*sel +: 8];
                    owned_funcs_n = owned_funcs | req_funcmask[8*sel +: 8];
                    pin_sh_n = (pin_sh & ~nib(req_pinmask[8*sel +: 8])) | (req_pinsel[32*sel +: 32] & nib(req_pinmask[8*sel +: 8]));
                    func_sh_n = (func_sh & ~nib(req_funcmask[8*sel +: 8])) | (req_funcsel[32*sel +: 32] & nib(req_funcmask[8*sel +: 8]));
                    rr_ptr_n = 2'((sel + 1) % NUM_REQ);
                    cur_n = 2'(sel);
                    acq_n = 1'b1;
                end
                if (rel >= 0 || sel >= 0) begin
                    state_n = WR_PIN;
                    wr_n = 1'b1;
                    addr_n = 2'd2;
                    data_n = pin_sh_n;
                end
            end
            WR_PIN: if (done) begin
                state_n = WR_FUNC;
                addr_n = 2'd3;
                data_n = func_sh;
            end
            WR_FUNC: if (done) begin
                state_n = IDLE;
                wr_n = 1'b0;
                if (acq) gnt_n[cur] = 1'b1;
            end
            default: state_n = INIT_PIN;
        endcase
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
        abort = avm_write && avm_waitrequest && to_cnt == 8'hFF;
        if (abort) begin
            state_n = IDLE;
            wr_n = 1'b0;
            // a failed acquisition leaves no trace; a failed release stays released
            if (acq && (state == WR_PIN || state == WR_FUNC)) begin
                owned_pins_n = owned_pins & ~lat_pin[8*cur +: 8];
                owned_funcs_n = owned_funcs & ~lat_func[8*cur +: 8];
                pin_sh_n = pin_save;
                func_sh_n = func_save;
            end
        end
`endif
    end

    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state <= INIT_PIN;
            cur <= '0;
            acq <= 1'b0;
            rr_ptr <= '0;
            gnt <= '0;
            owned_pins <= '0;
            owned_funcs <= '0;
            pin_sh <= DEFAULT_PINREGS;
            func_sh <= DEFAULT_FUNCREGS;
            lat_pin <= '0;
            lat_func <= '0;
            avm_write <= 1'b0;
            avm_address <= 2'd2;
            avm_writedata <= DEFAULT_PINREGS;
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
            to_cnt <= '0;
            err <= 1'b0;
            pin_save <= DEFAULT_PINREGS;
            func_save <= DEFAULT_FUNCREGS;
`endif
        end else begin
            state <= state_n;
            cur <= cur_n;
            acq <= acq_n;
            rr_ptr <= rr_ptr_n;
            gnt <= gnt_n;
            owned_pins <= owned_pins_n;
            owned_funcs <= owned_funcs_n;
            pin_sh <= pin_sh_n;
            func_sh <= func_sh_n;
            lat_pin <= lat_pin_n;
            lat_func <= lat_func_n;
            avm_write <= wr_n;
            avm_address <= addr_n;
            avm_writedata <= data_n;
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
            to_cnt <= (avm_write && avm_waitrequest && !abort) ? to_cnt + 8'd1 : 8'd0;
            err <= err | abort;
            pin_save <= (state == IDLE) ? pin_sh : pin_save;
            func_save <= (state == IDLE) ? func_sh : func_save;
`endif
        end
    end
endmodule

// File: tb/tb_peridot_pfc_sequencer.sv
// tb_peridot_pfc_sequencer: directed and randomized claims/releases checked against a transaction-level ownership model.
module tb_peridot_pfc_sequencer;
    localparam int N = 4;
    localparam logic [31:0] DP = 32'h0000_0000;
    localparam logic [31:0] DF = 32'h0000_0000;

    logic clock_sig = 1'b0;
    logic reset_sig;
    logic [1:0] avm_address;
    logic avm_write;
    logic [31:0] avm_writedata;
    logic avm_waitrequest;
    logic [N-1:0] req, gnt;
    logic [8*N-1:0] req_pinmask, req_funcmask;
    logic [32*N-1:0] req_pinsel, req_funcsel;
    logic [7:0] owned_pins;
    logic busy;
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
    logic err;
`endif

    peridot_pfc_sequencer #(.NUM_REQ(N), .DEFAULT_PINREGS(DP), .DEFAULT_FUNCREGS(DF)) dut (
        .clock_sig(clock_sig), .reset_sig(reset_sig),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .req(req), .req_pinmask(req_pinmask), .req_pinsel(req_pinsel),
        .req_funcmask(req_funcmask), .req_funcsel(req_funcsel),
        .gnt(gnt), .owned_pins(owned_pins),
`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clock_sig = ~clock_sig;

    typedef struct packed {logic [1:0] a; logic [31:0] d;} wr_t;
    wr_t act_q[$], exp_q[$];
    int gnt_order[$];
    logic [N-1:0] gnt_d = '0;
    int vectors = 0, miscompares = 0;
    int exp_ord[4] = '{2, 3, 0, 1};

    // model: who owns what, with masks/selects captured at grant time
    bit m_g[N];
    logic [7:0] m_pm[N], m_fm[N];
    logic [31:0] m_ps[N], m_fs[N];
    int m_rr;

    always @(negedge clock_sig) begin
        if (avm_write && !avm_waitrequest) act_q.push_back({avm_address, avm_writedata});
        for (int i = 0; i < N; i++) if (gnt[i] && !gnt_d[i]) gnt_order.push_back(i);
        gnt_d = gnt;
    end

    task automatic tick();
        @(posedge clock_sig);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nibs(input logic [7:0] m);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = m[i] ? 4'hF : 4'h0;
        return r;
    endfunction

    function automatic logic [31:0] shadow(input bit pin);
        logic [31:0] s;
        s = pin ? DP : DF;
        for (int c = 0; c < N; c++)
            if (m_g[c])
                for (int i = 0; i < 8; i++)
                    if (pin ? m_pm[c][i] : m_fm[c][i]) s[4*i +: 4] = pin ? m_ps[c][4*i +: 4] : m_fs[c][4*i +: 4];
        return s;
    endfunction

    task automatic model_resolve();
        int ev, c;
        logic [7:0] op, of;
        for (int g = 0; g < 16; g++) begin
            ev = -1;
            for (int j = N - 1; j >= 0; j--) if (m_g[j] && !req[j]) ev = j;
            if (ev >= 0) m_g[ev] = 1'b0;
            else begin
                op = '0;
                of = '0;
                for (int j = 0; j < N; j++) if (m_g[j]) begin op |= m_pm[j]; of |= m_fm[j]; end
                for (int i = 0; i < N; i++) begin
                    c = (m_rr + i) % N;
                    if (ev < 0 && req[c] && !m_g[c] && (req_pinmask[8*c +: 8] & op) == 0
                        && (req_funcmask[8*c +: 8] & of) == 0) ev = c;
                end
                if (ev < 0) return;
                m_g[ev] = 1'b1;
                m_pm[ev] = req_pinmask[8*ev +: 8];
                m_fm[ev] = req_funcmask[8*ev +: 8];
                m_ps[ev] = req_pinsel[32*ev +: 32];
                m_fs[ev] = req_funcsel[32*ev +: 32];
                m_rr = (ev + 1) % N;
            end
            exp_q.push_back({2'd2, shadow(1'b1)});
            exp_q.push_back({2'd3, shadow(1'b0)});
        end
    endtask

    task automatic settle();
        int quiet;
        quiet = 0;
        for (int t = 0; t < 3000 && quiet < 2; t++) begin
            tick();
            quiet = busy ? 0 : quiet + 1;
        end
        chk("settle", 32'(quiet >= 2), 32'd1);
    endtask

    task automatic check_all(input string tag);
        wr_t a, e;
        logic [N-1:0] eg;
        logic [7:0] eo;
        chk({tag, ".nwr"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, ".addr"}, 32'(a.a), 32'(e.a));
            chk({tag, ".data"}, a.d, e.d);
        end
        act_q.delete();
        exp_q.delete();
        eg = '0;
        eo = '0;
        for (int c = 0; c < N; c++) if (m_g[c]) begin eg[c] = 1'b1; eo |= m_pm[c]; end
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".owned"}, 32'(owned_pins), 32'(eo));
    endtask

    task automatic set_ch(input int c, input logic [7:0] pm, input logic [31:0] ps, input logic [7:0] fm, input logic [31:0] fs);
        req_pinmask[8*c +: 8] = pm;
        req_pinsel[32*c +: 32] = ps;
        req_funcmask[8*c +: 8] = fm;
        req_funcsel[32*c +: 32] = fs;
    endtask

    function automatic logic [7:0] rmask();
        logic [7:0] m;
        for (int b = 0; b < 8; b++) m[b] = $urandom_range(3) == 0;
        return m;
    endfunction

    initial begin
        int c;
        logic [31:0] d0;
        reset_sig = 1'b1;
        avm_waitrequest = 1'b0;
        req = '0;
        req_pinmask = '0;
        req_funcmask = '0;
        req_pinsel = '0;
        req_funcsel = '0;
        m_rr = 0;
        for (int i = 0; i < N; i++) begin m_g[i] = 1'b0; m_pm[i] = '0; m_fm[i] = '0; m_ps[i] = '0; m_fs[i] = '0; end
        repeat (3) tick();
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.owned", 32'(owned_pins), 32'd0);
        chk("rst.write", 32'(avm_write), 32'd0);
        chk("rst.busy", 32'(busy), 32'd1);
        act_q.delete();
        reset_sig = 1'b0;
        exp_q.push_back({2'd2, DP});
        exp_q.push_back({2'd3, DF});
        settle();
        check_all("init");

        set_ch(0, 8'h03, 32'h0000_00F8, 8'h01, 32'h0000_0008);
        req[0] = 1'b1;
        model_resolve();
        tick();
        chk("lat.wr1", 32'(avm_write), 32'd1);
        chk("lat.addr1", 32'(avm_address), 32'd2);
        chk("lat.data1", avm_writedata, 32'h0000_00F8);
        tick();
        chk("lat.addr2", 32'(avm_address), 32'd3);
        chk("lat.data2", avm_writedata, 32'h0000_0008);
        chk("lat.gnt2", 32'(gnt[0]), 32'd0);
        tick();
        chk("lat.gnt3", 32'(gnt[0]), 32'd1);
        settle();
        check_all("acq0");

        set_ch(1, 8'h02, $urandom, 8'h02, $urandom);
        req[1] = 1'b1;
        model_resolve();
        settle();
        check_all("conflict");
        chk("conflict.gnt1", 32'(gnt[1]), 32'd0);
        req[0] = 1'b0;
        model_resolve();
        settle();
        check_all("handover");
        chk("handover.gnt1", 32'(gnt[1]), 32'd1);

        req[1] = 1'b0;
        model_resolve();
        settle();
        check_all("rel1");
        for (int i = 0; i < N; i++) set_ch(i, 8'h01 << i, $urandom, 8'h10 << i, $urandom);
        gnt_order.delete();
        req = '1;
        model_resolve();
        settle();
        check_all("rr");
        chk("rr.count", 32'(gnt_order.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_order.size(); i++) chk("rr.order", 32'(gnt_order[i]), 32'(exp_ord[i]));

        req = '0;
        model_resolve();
        settle();
        check_all("relall");
        set_ch(0, 8'h30, $urandom, 8'h04, $urandom);
        avm_waitrequest = 1'b1;
        req[0] = 1'b1;
        model_resolve();
        d0 = exp_q[0].d;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t <= 6) begin
                chk("stall.wr", 32'(avm_write), 32'd1);
                chk("stall.addr", 32'(avm_address), 32'd2);
                chk("stall.data", avm_writedata, d0);
            end
            if (t == 6) avm_waitrequest = 1'b0;
            if (t == 7) chk("stall.gnt7", 32'(gnt[0]), 32'd0);
            if (t == 8) chk("stall.gnt8", 32'(gnt[0]), 32'd1);
        end
        settle();
        check_all("stall");

        for (int it = 0; it < 60; it++) begin
            c = $urandom_range(N - 1);
            if (req[c]) req[c] = 1'b0;
            else begin
                set_ch(c, rmask(), $urandom, rmask(), $urandom);
                req[c] = 1'b1;
            end
            for (int j = 0; j < N; j++)
                if (m_g[j] && req[j] && $urandom_range(1) == 1) set_ch(j, rmask(), $urandom, rmask(), $urandom);
            model_resolve();
            settle();
            check_all("rnd");
        end

`ifdef PERIDOT_PFC_SEQ_TIMEOUT_EN
        req = '0;
        model_resolve();
        settle();
        check_all("to.pre");
        set_ch(2, 8'h40, $urandom, 8'h00, $urandom);
        avm_waitrequest = 1'b1;
        req[2] = 1'b1;
        for (int t = 1; t <= 290; t++) begin
            tick();
            if (t == 200) req[2] = 1'b0;
            if (t == 250) chk("to.wr250", 32'(avm_write), 32'd1);
        end
        chk("to.wr290", 32'(avm_write), 32'd0);
        chk("to.err", 32'(err), 32'd1);
        chk("to.gnt", 32'(gnt), 32'd0);
        chk("to.owned", 32'(owned_pins), 32'd0);
        avm_waitrequest = 1'b0;
        model_resolve();
        settle();
        check_all("to.post");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/peridot_pfc_sequencer.md
Name: peridot_pfc_sequencer

Overview:
Shares the pin function controller between up to 4 requesters (e.g. SPI, I2C and UART cores on one PERIDOT header). Each requester claims a set of pin slots and function slots with its own select nibbles. The block checks claims for conflicts and arbitrates round-robin. It merges granted nibbles into shadow copies of pinsel/funcsel and programs the controller through an Avalon-MM master (word address 2 = pinsel, 3 = funcsel). On release, the owned nibbles return to their defaults and are rewritten.

Parameters:
NUM_REQ, 4, number of requester channels, 1-4
DEFAULT_PINREGS, 32'h00000000, pinsel value restored on reset/release; must match the controller default
DEFAULT_FUNCREGS, 32'h00000000, funcsel value restored on reset/release

Ports:
clock_sig  in  1  clock_sig, all logic posedge
reset_sig  in  1  reset_sig, asynchronous, active-high
avm_address  out  2  controller register word address
avm_write  out  1  write strobe
avm_writedata  out  32  write data
avm_waitrequest  in  1  slave stall
req  in  NUM_REQ  per-channel claim level; high = want, low = release
req_pinmask  in  8*NUM_REQ  channel n bits [8n+7:8n]; bit i = claims pin slot i (pinsel nibble i)
req_pinsel  in  32*NUM_REQ  pinsel nibbles for the claimed pins
req_funcmask  in  8*NUM_REQ  bit j = claims function slot j (funcsel nibble j)
req_funcsel  in  32*NUM_REQ  funcsel nibbles for the claimed functions
gnt  out  NUM_REQ  channel owns its slots; the controller is programmed
owned_pins  out  8  union of granted pin masks
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: state INIT; shadows = DEFAULT_*; gnt = 0; owned_pins = 0; owned_funcs = 0; rr_ptr = 0; avm_write = 0; busy = 1.
- States:
  - INIT_PIN and INIT_FUNC: write the defaults to addresses 2 and 3, then go to IDLE. This resynchronises the controller after any reset, including a reset mid-operation.
  - IDLE: evaluate one event per cycle.
  - WR_PIN: address 2, data = pin shadow.
  - WR_FUNC: address 3, data = func shadow.
- Avalon write: avm_write, address and data are registered and held stable while avm_waitrequest = 1. A write completes on a cycle with avm_write = 1 and avm_waitrequest = 0. avm_write = 0 in IDLE.
- Release is checked first. Release = any n with gnt[n] = 1 and req[n] = 0; lowest index wins.
  - Next edge: gnt[n] is cleared.
  - The channel's latched masks are removed from owned_pins/owned_funcs.
  - The masked shadow nibbles revert to DEFAULT_*.
  - The FSM goes to WR_PIN.
- Acquire: candidate n has req[n] = 1, gnt[n] = 0, (req_pinmask[n] & owned_pins) = 0 and (req_funcmask[n] & owned_funcs) = 0.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first candidate wins. Its masks are latched in per-channel registers, its masked nibbles are merged into the shadows, and ownership is ORed in.
  - rr_ptr becomes n+1 mod NUM_REQ. The FSM goes to WR_PIN, then WR_FUNC.
  - On WR_FUNC completion, gnt[n] is set and the FSM returns to IDLE.
- Latency: a request sampled at edge k with waitrequest = 0 gives WR_PIN in cycle k+1, WR_FUNC in k+2, and gnt high from k+3. Each waitrequest cycle adds one cycle.
- A conflicting request waits without a grant until the owner releases. Conflicting requests are not an error.
- Mask and select changes while granted are ignored; the latched masks govern release.
- req dropped before its grant: the grant is still issued, then released on the next IDLE cycle.
- Both masks zero: the channel is granted after the two writes (benign).
- Unclaimed nibbles always hold DEFAULT_* values.

Optional Feature:
PERIDOT_PFC_SEQ_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter runs while avm_waitrequest = 1. At 255 the write is abandoned and avm_write drops.
  - A sticky output err (1 bit, reset 0) is added; it is cleared only by reset.
  - Acquisition abort: ownership is rolled back, the shadows restore the pre-merge values, no grant is issued, and the FSM returns to IDLE.
  - Release abort: the release completes logically.
- Without the macro: no err port; the block waits indefinitely on waitrequest.

Test Plan:
- Reset, waitrequest = 0 -> writes addr2 = 0x00000000 then addr3 = 0x00000000; busy falls the cycle after; gnt = 0.
- ch0 req, pinmask 0x03, pinsel 0x000000F8, funcmask 0x01, funcsel 0x00000008 -> addr2 = 0x000000F8, addr3 = 0x00000008; gnt[0] 3 cycles after sampling.
- ch0 holds pins 0x03; ch1 requests pinmask 0x02 -> no write, gnt[1] = 0. ch0 drops req -> addr2/3 reverted to defaults, gnt[0] = 0, then ch1 programmed and granted.
- ch0-ch3 request disjoint masks in the same cycle with rr_ptr = 2 -> grant order 2, 3, 0, 1; 8 writes total.
- waitrequest held 5 cycles on WR_PIN -> address and data stable throughout; gnt delayed by 5 cycles.
- TIMEOUT_EN, waitrequest stuck at 1 -> avm_write drops after 255 cycles, err = 1, gnt stays 0, owned_pins unchanged.
